packet_switch_igr_pkt_arb: RTL and testbench

Packet-granular ingress arbiter for one packet-switch TX pipeline. It merges NUM_SRC AXI-Stream sources into the single egress stream toward HSSI: the user port is source 0 and the width-adjusted DMA channels are sources 1..NUM_SRC-1. The grant is held for a whole packet, through the beat with tlast. Sources are chosen round-robin, and source 0 can optionally be given strict priority. The egress is registered, and the block exports grant status for the debug counter blocks.

---
 rtl/packet_switch_igr_pkt_arb.sv | 132 +++++++++++++
 tb/tb_packet_switch_igr_pkt_arb.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_switch_igr_pkt_arb.sv
// Packet-granular ingress arbiter: merges NUM_SRC AXI-Stream sources into one
// registered egress stream, holding each grant from first beat through tlast.
module packet_switch_igr_pkt_arb #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_SRC-1:0]                       s_tvalid,
  output logic [NUM_SRC-1:0]                       s_tready,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]       s_tdata,
  input  logic [NUM_SRC-1:0][DATA_WIDTH/8-1:0]     s_tkeep,
  input  logic [NUM_SRC-1:0][USER_WIDTH-1:0]       s_tuser,
  input  logic [NUM_SRC-1:0]                       s_tlast,
  output logic                                     m_tvalid,
  input  logic                                     m_tready,
  output logic [DATA_WIDTH-1:0]                    m_tdata,
  output logic [DATA_WIDTH/8-1:0]                  m_tkeep,
  output logic [USER_WIDTH-1:0]                    m_tuser,
  output logic                                     m_tlast,
  input  logic                                     hi_prio_en,
  output logic [NUM_SRC-1:0]                       grant_onehot,
  output logic [NUM_SRC-1:0]                       grant_pulse,
  output logic                                     arb_busy
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {ST_IDLE, ST_OWN} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [IW-1:0]           r_gnt_idx;
  logic [IW-1:0]           r_rr_ptr;
  logic [NUM_SRC-1:0]      r_grant;
  logic                    r_pulse;
  logic [IW-1:0]           w_win_idx;
  logic [IW-1:0]           w_cand;
  logic                    w_found;
  logic                    w_take;
  logic                    w_egr_free;
  logic                    w_acc;
  logic                    w_acc_last;

  logic                    r_m_tvalid;
  logic [DATA_WIDTH-1:0]   r_m_tdata;
  logic [DATA_WIDTH/8-1:0] r_m_tkeep;
  logic [USER_WIDTH-1:0]   r_m_tuser;
  logic                    r_m_tlast;

  // Arbitration: source 0 pre-empts only at grant time; otherwise rotate from rr_ptr+1.
  always_comb begin
    w_win_idx = r_rr_ptr;
    w_cand    = '0;
    w_found   = 1'b0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      w_cand = IW'((int'(r_rr_ptr) + i) % NUM_SRC);
      if (!w_found && s_tvalid[w_cand]) begin
        w_win_idx = w_cand;
        w_found   = 1'b1;
      end
    end
    if (hi_prio_en && s_tvalid[0]) begin
      w_win_idx = '0;
    end
  end

  assign w_take     = (r_state == ST_IDLE) && (|s_tvalid);
  assign w_egr_free = !r_m_tvalid || m_tready;
  assign w_acc      = (r_state == ST_OWN) && s_tvalid[r_gnt_idx] && w_egr_free;
  assign w_acc_last = w_acc && s_tlast[r_gnt_idx];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (|s_tvalid)  w_state_nxt = ST_OWN;
      ST_OWN:  if (w_acc_last) w_state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0 -> p1: grant/state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= IW'(NUM_SRC - 1);
      r_gnt_idx <= '0;
      r_grant   <= '0;
      r_pulse   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pulse <= w_take;
      if (w_take) begin
        r_gnt_idx <= w_win_idx;
        r_rr_ptr  <= w_win_idx;
        r_grant   <= {{(NUM_SRC-1){1'b0}}, 1'b1} << w_win_idx;
      end else if (w_acc_last) begin
        r_grant <= '0;
      end
    end
  end

  // Stage p1 -> p2: single egress register, no skid buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tuser  <= '0;
      r_m_tlast  <= 1'b0;
    end else if (w_acc) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= s_tdata[r_gnt_idx];
      r_m_tkeep  <= s_tkeep[r_gnt_idx];
      r_m_tuser  <= s_tuser[r_gnt_idx];
      r_m_tlast  <= s_tlast[r_gnt_idx];
    end else if (m_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign s_tready     = ((r_state == ST_OWN) && w_egr_free) ? r_grant : '0;
  assign m_tvalid     = r_m_tvalid;
  assign m_tdata      = r_m_tdata;
  assign m_tkeep      = r_m_tkeep;
  assign m_tuser      = r_m_tuser;
  assign m_tlast      = r_m_tlast;
  assign grant_onehot = r_grant;
  assign grant_pulse  = r_pulse ? r_grant : '0;
  assign arb_busy     = (r_state == ST_OWN);

endmodule

// File: tb/tb_packet_switch_igr_pkt_arb.sv
// Directed bench for packet_switch_igr_pkt_arb: a packet-level reference model
// checked every cycle, plus hand-computed expectations for each scenario.
module tb_packet_switch_igr_pkt_arb;
  localparam int NS = 4;
  localparam int DW = 64;
  localparam int UW = 8;
  localparam int KW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [NS-1:0]          s_tvalid;
  logic [NS-1:0]          s_tready;
  logic [NS-1:0][DW-1:0]  s_tdata;
  logic [NS-1:0][KW-1:0]  s_tkeep;
  logic [NS-1:0][UW-1:0]  s_tuser;
  logic [NS-1:0]          s_tlast;
  logic                   m_tvalid;
  logic                   m_tready;
  logic [DW-1:0]          m_tdata;
  logic [KW-1:0]          m_tkeep;
  logic [UW-1:0]          m_tuser;
  logic                   m_tlast;
  logic                   hi_prio_en;
  logic [NS-1:0]          grant_onehot;
  logic [NS-1:0]          grant_pulse;
  logic                   arb_busy;

  packet_switch_igr_pkt_arb #(.NUM_SRC(NS), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .hi_prio_en(hi_prio_en), .grant_onehot(grant_onehot),
    .grant_pulse(grant_pulse), .arb_busy(arb_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-source packet streams waiting to be offered
  logic [DW-1:0] bd [NS][64];
  bit            bl [NS][64];
  int            hd [NS];
  int            tl [NS];
  bit            hold [NS];
  logic [NS-1:0] hs;

  task automatic push(input int s, input logic [DW-1:0] d, input bit l);
    if (tl[s] < 64) begin
      bd[s][tl[s]] = d;
      bl[s][tl[s]] = l;
      tl[s]++;
    end
  endtask

  task automatic clear_srcs();
    for (int s = 0; s < NS; s++) begin
      hd[s] = 0; tl[s] = 0; hold[s] = 1'b0;
    end
  endtask

  task automatic drive_inputs();
    for (int s = 0; s < NS; s++) begin
      if (hd[s] < tl[s] && !hold[s]) begin
        s_tvalid[s] = 1'b1;
        s_tdata[s]  = bd[s][hd[s]];
        s_tlast[s]  = bl[s][hd[s]];
      end else begin
        s_tvalid[s] = 1'b0;
        s_tdata[s]  = '0;
        s_tlast[s]  = 1'b0;
      end
      s_tkeep[s] = ~s_tdata[s][7:0];
      s_tuser[s] = s_tdata[s][15:8] + 8'(s);
    end
  endtask

  // Reference model: owner is a source number or -1, last_win is the rotation origin
  int            m_owner;
  int            m_last;
  bit            m_pulse;
  bit            mo_valid;
  logic [DW-1:0] mo_data;
  logic [KW-1:0] mo_keep;
  logic [UW-1:0] mo_user;
  bit            mo_last;

  task automatic model_reset();
    m_owner = -1; m_last = NS - 1; m_pulse = 1'b0;
    mo_valid = 1'b0; mo_data = '0; mo_keep = '0; mo_user = '0; mo_last = 1'b0;
  endtask

  function automatic int pick();
    if (hi_prio_en && s_tvalid[0]) return 0;
    for (int k = 1; k <= NS; k++) begin
      if (s_tvalid[(m_last + k) % NS]) return (m_last + k) % NS;
    end
    return -1;
  endfunction

  function automatic logic [NS-1:0] exp_ready();
    logic [NS-1:0] r;
    r = '0;
    if (m_owner >= 0 && (!mo_valid || m_tready)) r[m_owner] = 1'b1;
    return r;
  endfunction

  task automatic model_update();
    int  nxt;
    int  w;
    bit  acc;
    if (rst) begin
      model_reset();
    end else begin
      nxt = m_owner;
      acc = (m_owner >= 0) && s_tvalid[m_owner] && (!mo_valid || m_tready);
      if (acc) begin
        mo_valid = 1'b1;
        mo_data  = s_tdata[m_owner];
        mo_keep  = s_tkeep[m_owner];
        mo_user  = s_tuser[m_owner];
        mo_last  = s_tlast[m_owner];
        if (s_tlast[m_owner]) nxt = -1;
      end else if (m_tready) begin
        mo_valid = 1'b0;
      end
      m_pulse = 1'b0;
      if (m_owner < 0) begin
        w = pick();
        if (w >= 0) begin
          nxt = w; m_last = w; m_pulse = 1'b1;
        end
      end
      m_owner = nxt;
    end
  endtask

  function automatic logic [NS-1:0] owner_vec();
    return (m_owner >= 0) ? (NS'(1) << m_owner) : '0;
  endfunction

  task automatic compare_cycle();
    chk("s_tready", 64'(s_tready), 64'(exp_ready()));
    chk("m_tvalid", 64'(m_tvalid), 64'(mo_valid));
    if (mo_valid) begin
      chk("m_tdata", m_tdata, mo_data);
      chk("m_tkeep", 64'(m_tkeep), 64'(mo_keep));
      chk("m_tuser", 64'(m_tuser), 64'(mo_user));
      chk("m_tlast", 64'(m_tlast), 64'(mo_last));
    end
    chk("grant_onehot", 64'(grant_onehot), 64'(owner_vec()));
    chk("grant_pulse", 64'(grant_pulse), m_pulse ? 64'(owner_vec()) : 64'h0);
    chk("arb_busy", 64'(arb_busy), 64'(m_owner >= 0));
  endtask

  // Per-test traces and logs
  int            cyc;
  logic [63:0]   tr_mv [128];
  logic [63:0]   tr_md [128];
  logic [63:0]   tr_ml [128];
  logic [63:0]   tr_g  [128];
  logic [63:0]   tr_p  [128];
  logic [63:0]   tr_sr [128];
  logic [63:0]   tr_bz [128];
  int            gl_idx [64];
  int            gl_cyc [64];
  int            ngl;
  logic [DW-1:0] tx [64];
  int            ntx;

  task automatic step();
    drive_inputs();
    #1;
    compare_cycle();
    hs = s_tvalid & s_tready;
    if (cyc < 128) begin
      tr_mv[cyc] = 64'(m_tvalid); tr_md[cyc] = m_tdata; tr_ml[cyc] = 64'(m_tlast);
      tr_g[cyc]  = 64'(grant_onehot); tr_p[cyc] = 64'(grant_pulse);
      tr_sr[cyc] = 64'(s_tready); tr_bz[cyc] = 64'(arb_busy);
    end
    if (grant_pulse != '0 && ngl < 64) begin
      for (int s = 0; s < NS; s++) if (grant_pulse[s]) gl_idx[ngl] = s;
      gl_cyc[ngl] = cyc;
      ngl++;
    end
    if (m_tvalid && m_tready && ntx < 64) begin
      tx[ntx] = m_tdata;
      ntx++;
    end
    @(posedge clk);
    model_update();
    for (int s = 0; s < NS; s++) if (hs[s]) hd[s]++;
    @(negedge clk);
    cyc++;
  endtask

  task automatic reset_dut();
    rst = 1'b1; m_tready = 1'b1; hi_prio_en = 1'b0;
    clear_srcs();
    step();
    step();
    rst = 1'b0;
    cyc = 0; ngl = 0; ntx = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] acc3;
    rst = 1'b1; m_tready = 1'b1; hi_prio_en = 1'b0;
    clear_srcs();
    drive_inputs();
    @(negedge clk);
    @(negedge clk);
    model_reset();
    cyc = 0; ngl = 0; ntx = 0;
    #1;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'h0);
    chk("rst_m_tdata", m_tdata, 64'h0);
    chk("rst_s_tready", 64'(s_tready), 64'h0);
    chk("rst_grant", 64'(grant_onehot), 64'h0);
    chk("rst_pulse", 64'(grant_pulse), 64'h0);
    chk("rst_busy", 64'(arb_busy), 64'h0);
    @(negedge clk);

    // Single source, 3-beat packet
    reset_dut();
    push(2, 64'hA0, 1'b0); push(2, 64'hA1, 1'b0); push(2, 64'hA2, 1'b1);
    repeat (7) step();
    chk("t1_pulse_c1", tr_p[1], 64'h4);
    chk("t1_pulse_c2", tr_p[2], 64'h0);
    chk("t1_grant_c3", tr_g[3], 64'h4);
    chk("t1_grant_c4", tr_g[4], 64'h0);
    chk("t1_mv_c1", tr_mv[1], 64'h0);
    chk("t1_md_c2", tr_md[2], 64'hA0);
    chk("t1_md_c3", tr_md[3], 64'hA1);
    chk("t1_md_c4", tr_md[4], 64'hA2);
    chk("t1_ml_c4", tr_ml[4], 64'h1);
    chk("t1_mv_c5", tr_mv[5], 64'h0);

    // Round-robin, all sources continuously requesting 1-beat packets
    reset_dut();
    for (int k = 0; k < 8; k++)
      for (int s = 0; s < NS; s++) push(s, 64'(16'h100 * s + k), 1'b1);
    repeat (68) step();
    for (int i = 0; i < 8; i++) chk($sformatf("t2_order_%0d", i), 64'(gl_idx[i]), 64'(i % 4));
    chk("t2_first_cyc", 64'(gl_cyc[0]), 64'd1);
    chk("t2_src0_again", 64'(gl_cyc[4]), 64'd9);
    chk("t2_grants", 64'(ngl), 64'd32);
    chk("t2_beats", 64'(ntx), 64'd32);

    // Strict priority for source 0
    reset_dut();
    hi_prio_en = 1'b1;
    for (int k = 0; k < 6; k++) push(0, 64'(16'h500 + k), 1'b1);
    for (int k = 0; k < 3; k++) push(3, 64'(16'h530 + k), 1'b1);
    repeat (22) step();
    for (int i = 0; i < 6; i++) chk($sformatf("t3_prio_%0d", i), 64'(gl_idx[i]), 64'd0);
    chk("t3_src3_idx", 64'(gl_idx[6]), 64'd3);
    chk("t3_src3_cyc", 64'(gl_cyc[6]), 64'd13);
    acc3 = '0;
    for (int c = 0; c <= 12; c++) acc3 = acc3 | (tr_sr[c] & 64'h8);
    chk("t3_src3_starved", acc3, 64'h0);
    hi_prio_en = 1'b0;

    // Egress backpressure mid-packet
    reset_dut();
    push(1, 64'hB0, 1'b0); push(1, 64'hB1, 1'b0); push(1, 64'hB2, 1'b0); push(1, 64'hB3, 1'b1);
    for (int k = 0; k < 13; k++) begin
      m_tready = !(cyc >= 3 && cyc <= 7);
      step();
    end
    m_tready = 1'b1;
    for (int c = 3; c <= 7; c++) begin
      chk($sformatf("t4_hold_md_c%0d", c), tr_md[c], 64'hB1);
      chk($sformatf("t4_hold_sr_c%0d", c), tr_sr[c], 64'h0);
    end
    chk("t4_beats", 64'(ntx), 64'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("t4_tx_%0d", i), tx[i], 64'(8'hB0 + i));

    // Packet lock while the owner stalls
    reset_dut();
    push(1, 64'hC0, 1'b0); push(1, 64'hC1, 1'b0); push(1, 64'hC2, 1'b0); push(1, 64'hC3, 1'b1);
    push(2, 64'hD0, 1'b1);
    for (int k = 0; k < 14; k++) begin
      hold[1] = (cyc >= 3 && cyc <= 5);
      step();
    end
    hold[1] = 1'b0;
    for (int c = 1; c <= 7; c++) chk($sformatf("t5_lock_c%0d", c), tr_g[c], 64'h2);
    chk("t5_idle_c8", tr_g[8], 64'h0);
    chk("t5_second_idx", 64'(gl_idx[1]), 64'd2);
    chk("t5_second_cyc", 64'(gl_cyc[1]), 64'd9);
    chk("t5_beats", 64'(ntx), 64'd5);
    chk("t5_tx_last_c", tx[3], 64'hC3);
    chk("t5_tx_d", tx[4], 64'hD0);

    // Reset during beat 2 of a 4-beat packet
    reset_dut();
    push(3, 64'hE0, 1'b0); push(3, 64'hE1, 1'b0); push(3, 64'hE2, 1'b0); push(3, 64'hE3, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (cyc == 2) begin
        rst = 1'b1;
        push(0, 64'hF0, 1'b1);
      end
      if (cyc == 3) begin
        rst = 1'b0;
        hd[3] = 0; tl[3] = 0;
        push(3, 64'h60, 1'b1);
      end
      step();
    end
    chk("t6_pulse_c1", tr_p[1], 64'h8);
    chk("t6_mv_c3", tr_mv[3], 64'h0);
    chk("t6_md_c3", tr_md[3], 64'h0);
    chk("t6_grant_c3", tr_g[3], 64'h0);
    chk("t6_sr_c3", tr_sr[3], 64'h0);
    chk("t6_busy_c3", tr_bz[3], 64'h0);
    chk("t6_pulse_c4", tr_p[4], 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
